// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for lsu_mem_ctrl: the core-side request/response handshake and
// the byte-masked memory port.
// The slave modport is the LSU's view and the master modport is the environment's view.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holds valid and its payload
// steady until that edge, and valid never depends on ready.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_cs_n;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [1:0]  dbg_state;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready, mem_rdata, mem_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_cs_n, mem_rd, mem_addr, mem_be, mem_wdata, dbg_state
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready, mem_rdata, mem_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_cs_n, mem_rd, mem_addr, mem_be, mem_wdata, dbg_state
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between execute and a byte-masked data memory.
// Decodes funct3 into byte enables, lane-aligns store data, runs one memory
// access with ack/timeout and returns one sign/zero-extended response per request.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, a misaligned
// half or word access is answered with rsp_err instead of being truncated.
// The FSM state is visible on bus.dbg_state (IDLE=0, ACCESS=1, RESP=2).
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_illegal;
    logic        req_misalign;
    logic [3:0]  req_be;
    logic [31:0] req_lane_wdata;
    logic [31:0] load_ext;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Decode the incoming request: legality, alignment, byte enables and lane data.
    always_comb begin
        req_illegal    = 1'b0;
        req_misalign   = 1'b0;
        req_be         = 4'b0000;
        req_lane_wdata = bus.req_wdata;
        if (bus.req_we) begin
            req_illegal = (bus.req_funct3 >= 3'b011);
        end else begin
            req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                          (bus.req_funct3 == 3'b111);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        req_misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        // Low address bits below natural alignment are simply ignored below.
        req_misalign = 1'b0;
`endif
        case (bus.req_funct3[1:0])
            2'b00: begin
                req_be         = 4'b0001 << bus.req_addr[1:0];
                req_lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                req_be         = 4'b0011 << {bus.req_addr[1], 1'b0};
                req_lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                req_be         = 4'b1111;
                req_lane_wdata = bus.req_wdata;
            end
        endcase
    end

    // Extract the addressed lane of the raw memory word and extend it.
    always_comb begin
        byte_sh  = bus.mem_rdata >> {off_q, 3'b000};
        half_sh  = bus.mem_rdata >> {off_q[1], 4'b0000};
        load_ext = bus.mem_rdata;
        case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {24'd0, byte_sh[7:0]}
                                        : {{24{byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_ext = f3_q[2] ? {16'd0, half_sh[15:0]}
                                        : {{16{half_sh[15]}}, half_sh[15:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Next-state and captured-request logic for IDLE -> ACCESS -> RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d  = bus.req_we;
                    f3_d  = bus.req_funct3;
                    off_d = bus.req_addr[1:0];
                    if (req_illegal || req_misalign) begin
                        // Errors are answered directly without touching memory.
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = RESP;
                    end else begin
                        mem_addr_d  = {bus.req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_lane_wdata;
                        cnt_d       = 8'd0;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    // An ack in the final counted cycle still wins over the timeout.
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? 32'd0 : load_ext;
                    state_d     = RESP;
                end else if (cnt_q == TIMEOUT_M1) begin
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = 32'd0;
                    cnt_d       = 8'd0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Outputs decoded from state so chip select releases as soon as reset asserts.
    always_comb begin
        bus.req_ready = rst_n && (state_q == IDLE);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
        bus.mem_cs_n  = (state_q != ACCESS);
        bus.mem_rd    = (state_q == ACCESS) ? ~we_q : 1'b1;
        bus.mem_addr  = mem_addr_q;
        bus.mem_be    = mem_be_q;
        bus.mem_wdata = mem_wdata_q;
        bus.dbg_state = state_q;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl (TIMEOUT=4). Directed cases plus randomized
// transactions, checked against a byte-lane reference model.
module tb_lsu_mem_ctrl;

    localparam int TIMEOUT = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    lsu_mem_ctrl_if bus ();

    lsu_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and counters.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: everything derived from access size in bytes.
    function automatic int model_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit ill;
        if (we) ill = (f3 >= 3);
        else    ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
        if (ill) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((addr % model_size(f3)) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic int model_off(input logic [2:0] f3, input logic [31:0] addr);
        int a = int'(addr & 32'd3);
        return a - (a % model_size(f3));
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz = model_size(f3);
        return 4'(((1 << sz) - 1) << model_off(f3, addr));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] w;
        int sz = model_size(f3);
        w = 32'd0;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = 8'(wd >> (8 * (l % sz)));
        return w;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] word);
        logic [63:0] val;
        logic [63:0] mask;
        int sz = model_size(f3);
        val  = 64'(word) >> (8 * model_off(f3, addr));
        mask = (64'd1 << (8 * sz)) - 64'd1;
        val  = val & mask;
        if (!f3[2] && val[8*sz-1]) val = val | ~mask;
        return val[31:0];
    endfunction

    // Drive one request, act as the memory (ack after ack_wait ACCESS cycles,
    // never if ack_wait >= TIMEOUT), hold off rsp_ready for rsp_delay cycles.
    // Entered and left at #1 after a rising edge with the DUT in IDLE.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input int ack_wait, input int rsp_delay);
        bit          e_err  = model_err(we, f3, addr);
        bit          e_tmo  = !e_err && (ack_wait >= TIMEOUT);
        logic [31:0] e_rd;
        e_rd = (e_err || e_tmo || we) ? 32'd0 : model_rdata(f3, addr, word);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.mem_ack    = 1'($urandom_range(0, 1));
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        step();
        bus.req_valid  = 1'b0;
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        if (!e_err) begin
            for (int k = 0; k < TIMEOUT; k++) begin
                check("cs_n_access", 32'(bus.mem_cs_n), 32'd0);
                check("mem_rd", 32'(bus.mem_rd), 32'(!we));
                check("mem_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
                check("mem_be", 32'(bus.mem_be), 32'(model_be(f3, addr)));
                if (we) check("mem_wdata", bus.mem_wdata, model_wdata(f3, wdata));
                check("rsp_valid_access", 32'(bus.rsp_valid), 32'd0);
                bus.mem_ack   = (k == ack_wait);
                bus.mem_rdata = (k == ack_wait) ? word : $urandom;
                step();
                bus.mem_ack   = 1'b0;
                if (k == ack_wait) break;
            end
        end else begin
            check("cs_n_err", 32'(bus.mem_cs_n), 32'd1);
        end
        for (int d = 0; d <= rsp_delay; d++) begin
            check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("rsp_rdata", bus.rsp_rdata, e_rd);
            check("rsp_err", 32'(bus.rsp_err), 32'(e_err || e_tmo));
            check("cs_n_resp", 32'(bus.mem_cs_n), 32'd1);
            check("req_ready_resp", 32'(bus.req_ready), 32'd0);
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.rsp_ready = (d == rsp_delay);
            step();
            bus.rsp_ready = 1'b0;
        end
        bus.mem_ack = 1'b0;
        check("rsp_valid_done", 32'(bus.rsp_valid), 32'd0);
        check("req_ready_next", 32'(bus.req_ready), 32'd1);
    endtask

    // Main sequence: reset, directed cases, random traffic, report.
    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        bus.mem_rdata  = 32'd0;
        bus.mem_ack    = 1'b0;
        step();
        step();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_cs_n", 32'(bus.mem_cs_n), 32'd1);
        check("rst_mem_rd", 32'(bus.mem_rd), 32'd1);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Store half, zero wait states.
        run_txn(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'd0, 0, 0);
        // Loads from one memory word.
        run_txn(1'b0, 3'b000, 32'h1, 32'd0, 32'h80F1_7F00, 0, 0);
        run_txn(1'b0, 3'b000, 32'h3, 32'd0, 32'h80F1_7F00, 1, 0);
        run_txn(1'b0, 3'b100, 32'h3, 32'd0, 32'h80F1_7F00, 0, 1);
        run_txn(1'b0, 3'b001, 32'h2, 32'd0, 32'h80F1_7F00, 2, 0);
        run_txn(1'b0, 3'b101, 32'h2, 32'd0, 32'h80F1_7F00, 0, 0);
        run_txn(1'b0, 3'b010, 32'h0, 32'd0, 32'h80F1_7F00, 0, 0);
        // Timeout, then ack in the last allowed cycle.
        run_txn(1'b0, 3'b010, 32'h40, 32'd0, 32'h1234_5678, TIMEOUT + 3, 0);
        run_txn(1'b0, 3'b010, 32'h40, 32'd0, 32'h1234_5678, TIMEOUT - 1, 0);
        // Misaligned word, illegal load and store funct3.
        run_txn(1'b0, 3'b010, 32'h6, 32'd0, 32'hCAFE_F00D, 0, 0);
        run_txn(1'b0, 3'b011, 32'h8, 32'd0, 32'hCAFE_F00D, 0, 0);
        run_txn(1'b1, 3'b100, 32'h8, 32'h55, 32'd0, 0, 0);
        // Backpressure for 5 cycles, then back-to-back request.
        run_txn(1'b0, 3'b001, 32'h22, 32'd0, 32'hA5A5_1234, 0, 5);
        run_txn(1'b1, 3'b000, 32'h23, 32'h0000_00C3, 32'd0, 0, 0);

        // Reset in the middle of an access.
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        step();
        bus.req_valid = 1'b0;
        check("mid_cs_n_low", 32'(bus.mem_cs_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", 32'(bus.mem_cs_n), 32'd1);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_rel_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rel_be", 32'(bus.mem_be), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom, $urandom_range(0, TIMEOUT + 1), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
